serial_bus_arbiter: RTL and testbench

//  Arbitrates ownership of the shared single-wire serial data bus and the slave_busy line among
//  NUM_MASTERS masters. Issues one-hot registered grants and drives bus_util to every slave.

---
 rtl/serial_bus_arbiter.sv | 164 ++++++++++++++++
 tb/tb_serial_bus_arbiter.sv | 338 +++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/serial_bus_arbiter.sv
// rtl/serial_bus_arbiter.sv - one-hot serial bus arbiter with turnaround gaps; optional ARB_TIMEOUT_EN
// ARB_TIMEOUT_EN bounds each ownership to TIMEOUT_CYCLES and reports the forced release.
module serial_bus_arbiter #(
  parameter int NUM_MASTERS    = 4,
  parameter int ARB_MODE       = 0,
  parameter int TURNAROUND     = 2,
  parameter int TIMEOUT_CYCLES = 255,
  localparam int ID_W          = $clog2(NUM_MASTERS)
) (
  input  logic                   clk,
  input  logic                   rstn,
  input  logic [NUM_MASTERS-1:0] req,
  input  logic                   slave_busy,
  output logic [NUM_MASTERS-1:0] grant,
  output logic [ID_W-1:0]        grant_id,
  output logic                   bus_util,
  output logic                   timeout,
  output logic [ID_W-1:0]        timeout_id
);

  localparam int TC_W = (TURNAROUND > 1) ? $clog2(TURNAROUND) : 1;

  typedef enum logic [1:0] {IDLE, OWNED, TURN} state_t;

  state_t                 state_q, state_d;
  logic [NUM_MASTERS-1:0] grant_q, grant_d;
  logic [ID_W-1:0]        grant_id_q, grant_id_d;
  logic [ID_W-1:0]        rr_ptr_q, rr_ptr_d;
  logic [TC_W-1:0]        turn_cnt_q, turn_cnt_d;
  logic                   bus_util_q, bus_util_d;
  logic                   win_found;
  logic [ID_W-1:0]        win_id;
  int                     idx;

`ifdef ARB_TIMEOUT_EN
  localparam int HOLD_W = $clog2(TIMEOUT_CYCLES);
  logic [HOLD_W-1:0]      hold_cnt_q, hold_cnt_d;
  logic                   timeout_q, timeout_d;
  logic [ID_W-1:0]        timeout_id_q, timeout_id_d;
`endif

  // Loops run backwards so the first match in search order is the last assignment.
  always_comb begin
    win_found = 1'b0;
    win_id    = '0;
    idx       = 0;
    if (ARB_MODE == 1) begin
      for (int i = NUM_MASTERS - 1; i >= 0; i--) begin
        if (req[ID_W'(i)]) begin
          win_found = 1'b1;
          win_id    = ID_W'(i);
        end
      end
    end else begin
      for (int i = NUM_MASTERS; i >= 1; i--) begin
        idx = (int'(rr_ptr_q) + i) % NUM_MASTERS;
        if (req[ID_W'(idx)]) begin
          win_found = 1'b1;
          win_id    = ID_W'(idx);
        end
      end
    end
  end

  always_comb begin
    state_d    = state_q;
    grant_d    = grant_q;
    grant_id_d = grant_id_q;
    rr_ptr_d   = rr_ptr_q;
    turn_cnt_d = turn_cnt_q;
`ifdef ARB_TIMEOUT_EN
    hold_cnt_d   = hold_cnt_q;
    timeout_d    = 1'b0;
    timeout_id_d = timeout_id_q;
`endif
    case (state_q)
      IDLE: begin
        if (win_found) begin
          grant_d         = '0;
          grant_d[win_id] = 1'b1;
          grant_id_d      = win_id;
          if (ARB_MODE == 0) rr_ptr_d = win_id;
          state_d = OWNED;
`ifdef ARB_TIMEOUT_EN
          hold_cnt_d = '0;
`endif
        end
      end
      OWNED: begin
`ifdef ARB_TIMEOUT_EN
        if (hold_cnt_q == HOLD_W'(TIMEOUT_CYCLES - 1)) begin
          timeout_d    = 1'b1;
          timeout_id_d = grant_id_q;
          grant_d      = '0;
          turn_cnt_d   = '0;
          state_d      = TURN;
        end else begin
          hold_cnt_d = hold_cnt_q + 1'b1;
          if (!req[grant_id_q] && !slave_busy) begin
            grant_d    = '0;
            turn_cnt_d = '0;
            state_d    = TURN;
          end
        end
`else
        if (!req[grant_id_q] && !slave_busy) begin
          grant_d    = '0;
          turn_cnt_d = '0;
          state_d    = TURN;
        end
`endif
      end
      TURN: begin
        if (turn_cnt_q == TC_W'(TURNAROUND - 1)) state_d = IDLE;
        else turn_cnt_d = turn_cnt_q + 1'b1;
      end
      default: begin
        state_d = IDLE;
        grant_d = '0;
      end
    endcase
    bus_util_d = |grant_d;
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_q    <= IDLE;
      grant_q    <= '0;
      grant_id_q <= '0;
      rr_ptr_q   <= ID_W'(NUM_MASTERS - 1);
      turn_cnt_q <= '0;
      bus_util_q <= 1'b0;
`ifdef ARB_TIMEOUT_EN
      hold_cnt_q   <= '0;
      timeout_q    <= 1'b0;
      timeout_id_q <= '0;
`endif
    end else begin
      state_q    <= state_d;
      grant_q    <= grant_d;
      grant_id_q <= grant_id_d;
      rr_ptr_q   <= rr_ptr_d;
      turn_cnt_q <= turn_cnt_d;
      bus_util_q <= bus_util_d;
`ifdef ARB_TIMEOUT_EN
      hold_cnt_q   <= hold_cnt_d;
      timeout_q    <= timeout_d;
      timeout_id_q <= timeout_id_d;
`endif
    end
  end

  assign grant    = grant_q;
  assign grant_id = grant_id_q;
  assign bus_util = bus_util_q;
`ifdef ARB_TIMEOUT_EN
  assign timeout    = timeout_q;
  assign timeout_id = timeout_id_q;
`else
  assign timeout    = 1'b0;
  assign timeout_id = '0;
`endif

endmodule

// File: tb/tb_serial_bus_arbiter.sv
// tb/tb_serial_bus_arbiter.sv - directed bench for serial_bus_arbiter (round-robin and fixed instances)
module tb_serial_bus_arbiter;

  localparam int N = 4;
  localparam int T = 2;

  logic         clk;
  logic         rstn;
  logic [N-1:0] req;
  logic         slave_busy;
  logic [N-1:0] grant, grant_fp;
  logic [1:0]   grant_id, grant_id_fp, timeout_id, timeout_id_fp;
  logic         bus_util, bus_util_fp, timeout, timeout_fp;

  int n_checks = 0;
  int n_fail   = 0;

  serial_bus_arbiter #(.NUM_MASTERS(N), .ARB_MODE(0), .TURNAROUND(T), .TIMEOUT_CYCLES(16)) dut (
    .clk(clk), .rstn(rstn), .req(req), .slave_busy(slave_busy),
    .grant(grant), .grant_id(grant_id), .bus_util(bus_util),
    .timeout(timeout), .timeout_id(timeout_id)
  );

  serial_bus_arbiter #(.NUM_MASTERS(N), .ARB_MODE(1), .TURNAROUND(T), .TIMEOUT_CYCLES(16)) dut_fp (
    .clk(clk), .rstn(rstn), .req(req), .slave_busy(slave_busy),
    .grant(grant_fp), .grant_id(grant_id_fp), .bus_util(bus_util_fp),
    .timeout(timeout_fp), .timeout_id(timeout_id_fp)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  always @(negedge clk) begin
    if (rstn) begin
      n_checks++;
      if (!$onehot0(grant) || bus_util !== |grant) begin
        n_fail++;
        $display("FAIL rr_onehot_util grant=%b bus_util=%b", grant, bus_util);
      end
      n_checks++;
      if (!$onehot0(grant_fp) || bus_util_fp !== |grant_fp) begin
        n_fail++;
        $display("FAIL fp_onehot_util grant=%b bus_util=%b", grant_fp, bus_util_fp);
      end
    end
  end

  task automatic step;
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset;
    rstn = 1'b0;
    req = '0;
    slave_busy = 1'b0;
    step;
    step;
    #2 rstn = 1'b1;
  endtask

  task automatic drain;
    req = '0;
    slave_busy = 1'b0;
    repeat (T + 3) step;
  endtask

  task automatic test_reset;
    rstn = 1'b0;
    req = '0;
    slave_busy = 1'b0;
    step;
    step;
    n_checks++;
    if (grant !== 4'b0000 || bus_util !== 1'b0 || grant_id !== 2'd0) begin
      n_fail++;
      $display("FAIL reset_outputs grant=%b bus_util=%b grant_id=%0d want 0000/0/0", grant, bus_util, grant_id);
    end
    n_checks++;
    if (timeout !== 1'b0 || timeout_id !== 2'd0 || grant_fp !== 4'b0000) begin
      n_fail++;
      $display("FAIL reset_timeout timeout=%b timeout_id=%0d grant_fp=%b want 0/0/0000", timeout, timeout_id, grant_fp);
    end
    #2 rstn = 1'b1;
  endtask

  task automatic test_basic;
    req = 4'b0001;
    step;
    n_checks++;
    if (grant !== 4'b0001 || bus_util !== 1'b1 || grant_id !== 2'd0) begin
      n_fail++;
      $display("FAIL basic_grant grant=%b bus_util=%b grant_id=%0d want 0001/1/0", grant, bus_util, grant_id);
    end
    repeat (3) step;
    n_checks++;
    if (grant !== 4'b0001) begin
      n_fail++;
      $display("FAIL basic_hold grant=%b want 0001", grant);
    end
    req = 4'b0000;
    step;
    n_checks++;
    if (grant !== 4'b0000 || bus_util !== 1'b0) begin
      n_fail++;
      $display("FAIL basic_release grant=%b bus_util=%b want 0000/0", grant, bus_util);
    end
    req = 4'b0001;
    for (int e = 0; e < T; e++) begin
      step;
      n_checks++;
      if (grant !== 4'b0000) begin
        n_fail++;
        $display("FAIL basic_turnaround grant=%b want 0000 at turn cycle %0d", grant, e);
      end
    end
    step;
    n_checks++;
    if (grant !== 4'b0001) begin
      n_fail++;
      $display("FAIL basic_regrant grant=%b want 0001", grant);
    end
    drain;
  endtask

  task automatic test_rr;
    int order[5] = '{0, 1, 2, 3, 0};
    logic [N-1:0] exp;
    int zeros;
    do_reset;
    req = 4'b1111;
    zeros = 0;
    for (int k = 0; k < 5; k++) begin
      for (int c = 0; c < 12 && grant === 4'b0000; c++) begin
        step;
        if (grant === 4'b0000) zeros++;
      end
      exp = 4'b0001 << order[k];
      n_checks++;
      if (grant !== exp || grant_id !== 2'(order[k])) begin
        n_fail++;
        $display("FAIL rr_order k=%0d grant=%b grant_id=%0d want %b/%0d", k, grant, grant_id, exp, order[k]);
      end
      if (k > 0) begin
        n_checks++;
        if (zeros !== T + 1) begin
          n_fail++;
          $display("FAIL rr_gap k=%0d idle_cycles=%0d want %0d", k, zeros, T + 1);
        end
      end
      step;
      step;
      req[order[k]] = 1'b0;
      step;
      n_checks++;
      if (grant !== 4'b0000) begin
        n_fail++;
        $display("FAIL rr_release k=%0d grant=%b want 0000", k, grant);
      end
      req[order[k]] = 1'b1;
      zeros = 1;
    end
    drain;
  endtask

  task automatic test_fixed;
    bit saw3;
    do_reset;
    saw3 = 1'b0;
    req = 4'b1010;
    for (int k = 0; k < 3; k++) begin
      for (int c = 0; c < 12 && grant_fp === 4'b0000; c++) begin
        step;
        saw3 |= grant_fp[3];
      end
      n_checks++;
      if (grant_fp !== 4'b0010 || grant_id_fp !== 2'd1) begin
        n_fail++;
        $display("FAIL fixed_grant k=%0d grant=%b grant_id=%0d want 0010/1", k, grant_fp, grant_id_fp);
      end
      step;
      step;
      req[1] = 1'b0;
      step;
      saw3 |= grant_fp[3];
      req[1] = 1'b1;
    end
    n_checks++;
    if (saw3 !== 1'b0) begin
      n_fail++;
      $display("FAIL fixed_starve saw_master3=%b want 0", saw3);
    end
    drain;
  endtask

  task automatic test_busy;
    do_reset;
    req = 4'b0100;
    step;
    n_checks++;
    if (grant !== 4'b0100) begin
      n_fail++;
      $display("FAIL busy_grant grant=%b want 0100", grant);
    end
    slave_busy = 1'b1;
    req = 4'b0000;
    for (int c = 0; c < 6; c++) begin
      step;
      n_checks++;
      if (grant !== 4'b0100) begin
        n_fail++;
        $display("FAIL busy_hold cycle=%0d grant=%b want 0100", c, grant);
      end
    end
    slave_busy = 1'b0;
    step;
    n_checks++;
    if (grant !== 4'b0000 || bus_util !== 1'b0) begin
      n_fail++;
      $display("FAIL busy_release grant=%b bus_util=%b want 0000/0", grant, bus_util);
    end
    drain;
  endtask

  task automatic test_timeout;
    do_reset;
`ifdef ARB_TIMEOUT_EN
    req = 4'b1100;
    step;
    n_checks++;
    if (grant !== 4'b0100) begin
      n_fail++;
      $display("FAIL to_grant grant=%b want 0100", grant);
    end
    for (int c = 1; c < 16; c++) begin
      step;
      n_checks++;
      if (grant !== 4'b0100 || timeout !== 1'b0) begin
        n_fail++;
        $display("FAIL to_hold cycle=%0d grant=%b timeout=%b want 0100/0", c, grant, timeout);
      end
    end
    step;
    n_checks++;
    if (grant !== 4'b0000 || timeout !== 1'b1 || timeout_id !== 2'd2) begin
      n_fail++;
      $display("FAIL to_release grant=%b timeout=%b timeout_id=%0d want 0000/1/2", grant, timeout, timeout_id);
    end
    step;
    n_checks++;
    if (timeout !== 1'b0 || timeout_id !== 2'd2) begin
      n_fail++;
      $display("FAIL to_pulse timeout=%b timeout_id=%0d want 0/2", timeout, timeout_id);
    end
    repeat (T - 1) step;
    n_checks++;
    if (grant !== 4'b0000) begin
      n_fail++;
      $display("FAIL to_turn grant=%b want 0000", grant);
    end
    step;
    n_checks++;
    if (grant !== 4'b1000 || grant_id !== 2'd3) begin
      n_fail++;
      $display("FAIL to_next grant=%b grant_id=%0d want 1000/3", grant, grant_id);
    end
`else
    req = 4'b0100;
    step;
    repeat (40) step;
    n_checks++;
    if (grant !== 4'b0100 || timeout !== 1'b0 || timeout_id !== 2'd0) begin
      n_fail++;
      $display("FAIL unbounded_hold grant=%b timeout=%b timeout_id=%0d want 0100/0/0", grant, timeout, timeout_id);
    end
    req = 4'b0000;
    step;
    n_checks++;
    if (grant !== 4'b0000) begin
      n_fail++;
      $display("FAIL unbounded_release grant=%b want 0000", grant);
    end
`endif
    drain;
  endtask

  task automatic test_reset_mid;
    do_reset;
    req = 4'b0100;
    step;
    step;
    n_checks++;
    if (grant !== 4'b0100) begin
      n_fail++;
      $display("FAIL midrst_grant grant=%b want 0100", grant);
    end
    #2 rstn = 1'b0;
    #1;
    n_checks++;
    if (grant !== 4'b0000 || bus_util !== 1'b0 || grant_id !== 2'd0) begin
      n_fail++;
      $display("FAIL midrst_async grant=%b bus_util=%b grant_id=%0d want 0000/0/0", grant, bus_util, grant_id);
    end
    req = 4'b1010;
    #2 rstn = 1'b1;
    step;
    n_checks++;
    if (grant !== 4'b0010 || grant_id !== 2'd1) begin
      n_fail++;
      $display("FAIL midrst_ptr grant=%b grant_id=%0d want 0010/1", grant, grant_id);
    end
    drain;
  endtask

  initial begin
    #300000;
    $display("FAIL watchdog simulation time limit reached");
    $fatal(1);
  end

  initial begin
    rstn = 1'b0;
    req = '0;
    slave_busy = 1'b0;
    test_reset;
    test_basic;
    test_rr;
    test_fixed;
    test_busy;
    test_timeout;
    test_reset_mid;
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
